// File: rtl/serial_hram_bridge.sv
// Purpose: assembles 5-byte UART command frames, drives hyper_xface requests, streams a 4-byte big-endian reply.
// Latency: first tx_start one cycle after leaving EXEC when tx_ready=1; memory commands add busy/rd_rdy wait.
// Backpressure: each reply byte waits for tx_ready; bytes arriving outside RX are dropped and flagged on overrun.
module serial_hram_bridge #(
    parameter int unsigned FRAME_TIMEOUT = 24000000,
    parameter int unsigned RD_TIMEOUT    = 1024,
    parameter logic [31:0] CONST_VAL     = 32'd259
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  rx_data,
    input  logic        rx_rcv,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_ready,
    output logic [31:0] addr,
    output logic [31:0] wr_d,
    output logic        wr_req,
    output logic        rd_req,
    input  logic [31:0] rd_d,
    input  logic        rd_rdy,
    input  logic        busy,
    output logic        overrun
);

    localparam logic [31:0] FT_LAST = 32'(FRAME_TIMEOUT - 1);
    localparam logic [31:0] RD_TO   = 32'(RD_TIMEOUT);

    typedef enum logic [2:0] {
        S_RX,
        S_EXEC,
        S_WAIT_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_TX_BYTE,
        S_TX_HOLD,
        S_TX_WAIT
    } state_t;

    state_t      state_q;
    logic [2:0]  byte_cnt_q;
    logic [31:0] ftimer_q;
    logic [7:0]  cmd_q;
    logic [31:0] data_q;
    logic [31:0] resp_q;
    logic [31:0] rd_latch_q;
    logic [31:0] count_q;
    logic [31:0] count_d;
    logic [31:0] to_q;
    logic        is_wr_q;
    logic        seen_busy_q;
    logic [1:0]  tx_idx_q;
    logic        hold_q;
    logic [7:0]  tx_data_q;
    logic        tx_start_q;
    logic [31:0] addr_q;
    logic [31:0] wr_d_q;
    logic        wr_req_q;
    logic        rd_req_q;
    logic        overrun_q;

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign addr     = addr_q;
    assign wr_d     = wr_d_q;
    assign wr_req   = wr_req_q;
    assign rd_req   = rd_req_q;
    assign overrun  = overrun_q;

    // Next value of the COUNT command register (wraps naturally at 32 bits).
    always_comb begin
        count_d = count_q + 32'd1;
    end

    // Sticky flag: any byte that arrives while the engine is not collecting a frame is lost.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overrun_q <= 1'b0;
        end else if (rx_rcv && (state_q != S_RX)) begin
            overrun_q <= 1'b1;
        end
    end

    // Main command engine: frame assembly, command execution, memory handshake and reply serialiser.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_RX;
            byte_cnt_q  <= 3'd0;
            ftimer_q    <= 32'd0;
            cmd_q       <= 8'd0;
            data_q      <= 32'd0;
            resp_q      <= 32'd0;
            rd_latch_q  <= 32'd0;
            count_q     <= 32'd0;
            to_q        <= 32'd0;
            is_wr_q     <= 1'b0;
            seen_busy_q <= 1'b0;
            tx_idx_q    <= 2'd0;
            hold_q      <= 1'b0;
            tx_data_q   <= 8'd0;
            tx_start_q  <= 1'b0;
            addr_q      <= 32'd0;
            wr_d_q      <= 32'd0;
            wr_req_q    <= 1'b0;
            rd_req_q    <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            tx_start_q <= 1'b0;
            wr_req_q   <= 1'b0;
            rd_req_q   <= 1'b0;

            case (state_q)
                S_RX: begin
                    if (rx_rcv) begin
                        ftimer_q <= 32'd0;
                        if (byte_cnt_q == 3'd0) begin
                            cmd_q <= rx_data;
                        end else begin
                            data_q <= {data_q[23:0], rx_data};
                        end
                        if (byte_cnt_q == 3'd4) begin
                            byte_cnt_q <= 3'd0;
                            state_q    <= S_EXEC;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 3'd1;
                        end
                    end else if (byte_cnt_q != 3'd0) begin
                        // A stalled partial frame is silently abandoned.
                        if (ftimer_q == FT_LAST) begin
                            byte_cnt_q <= 3'd0;
                            ftimer_q   <= 32'd0;
                        end else begin
                            ftimer_q <= ftimer_q + 32'd1;
                        end
                    end
                end

                S_EXEC: begin
                    tx_idx_q <= 2'd0;
                    state_q  <= S_TX_BYTE;
                    case (cmd_q)
                        8'h01: begin
                            addr_q <= data_q;
                            resp_q <= data_q;
                        end
                        8'h02: begin
                            wr_d_q <= data_q;
                            resp_q <= data_q;
                        end
                        8'h03, 8'h05: begin
                            is_wr_q <= (cmd_q == 8'h03);
                            to_q    <= RD_TO;
                            state_q <= S_WAIT_IDLE;
                        end
                        8'h04: resp_q <= rd_latch_q;
                        8'h06: begin
                            resp_q  <= count_q;
                            count_q <= count_d;
                        end
                        8'h07:   resp_q <= CONST_VAL;
                        default: resp_q <= 32'hFFFF_FFFF;
                    endcase
                end

                S_WAIT_IDLE: begin
                    if (!busy) begin
                        // Raise the request so it is high for exactly the ISSUE cycle.
                        wr_req_q <= is_wr_q;
                        rd_req_q <= !is_wr_q;
                        state_q  <= S_ISSUE;
                    end else if (to_q == 32'd0) begin
                        resp_q  <= 32'hDEAD_BEEF;
                        state_q <= S_TX_BYTE;
                    end else begin
                        to_q <= to_q - 32'd1;
                    end
                end

                S_ISSUE: begin
                    to_q        <= RD_TO;
                    seen_busy_q <= 1'b0;
                    state_q     <= S_WAIT_DONE;
                end

                S_WAIT_DONE: begin
                    if (is_wr_q && seen_busy_q && !busy) begin
                        resp_q  <= 32'h0000_0003;
                        state_q <= S_TX_BYTE;
                    end else if (!is_wr_q && rd_rdy) begin
                        rd_latch_q <= rd_d;
                        resp_q     <= rd_d;
                        state_q    <= S_TX_BYTE;
                    end else if (to_q == 32'd0) begin
                        resp_q  <= 32'hDEAD_BEEF;
                        state_q <= S_TX_BYTE;
                    end else begin
                        to_q <= to_q - 32'd1;
                        if (busy) begin
                            seen_busy_q <= 1'b1;
                        end
                    end
                end

                S_TX_BYTE: begin
                    if (tx_ready) begin
                        tx_data_q  <= resp_q[31:24];
                        resp_q     <= {resp_q[23:0], 8'h00};
                        tx_start_q <= 1'b1;
                        hold_q     <= 1'b1;
                        state_q    <= S_TX_HOLD;
                    end
                end

                S_TX_HOLD: begin
                    // Give uart_tx time to drop tx_ready after the start strobe.
                    if (hold_q) begin
                        hold_q <= 1'b0;
                    end else begin
                        state_q <= S_TX_WAIT;
                    end
                end

                S_TX_WAIT: begin
                    if (tx_ready) begin
                        if (tx_idx_q == 2'd3) begin
                            tx_idx_q <= 2'd0;
                            state_q  <= S_RX;
                        end else begin
                            tx_idx_q <= tx_idx_q + 2'd1;
                            state_q  <= S_TX_BYTE;
                        end
                    end
                end

                default: state_q <= S_RX;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_hram_bridge.sv
// Directed bench for serial_hram_bridge with small uart_tx and hyper_xface behavioural models.
// Replies are collected byte-by-byte from tx_start strobes and assembled big-endian.
// Each scenario task compares observed values against hand-computed constants.
module tb_serial_hram_bridge;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_rcv = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_ready = 1'b1;
    logic [31:0] addr;
    logic [31:0] wr_d;
    logic        wr_req;
    logic        rd_req;
    logic [31:0] rd_d = 32'd0;
    logic        rd_rdy = 1'b0;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    // uart_tx model state
    logic [7:0] tx_q[$];
    int         txr_cnt = 0;

    // hyper_xface model state
    logic        busy_force = 1'b0;
    int          wr_busy_cnt = 0;
    int          wr_pulses = 0;
    logic [31:0] wr_d_seen = 32'd0;
    int          rd_pulses = 0;
    logic        rd_respond = 1'b0;
    logic [31:0] rd_val = 32'd0;
    int          rd_wait_cnt = 0;

    // reply collection
    logic [31:0] resp_w;
    int          resp_n;

    always #5 clk = ~clk;

    assign busy = busy_force || (wr_busy_cnt != 0);

    serial_hram_bridge #(
        .FRAME_TIMEOUT(100),
        .RD_TIMEOUT(1024),
        .CONST_VAL(32'd259)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .rx_data(rx_data),
        .rx_rcv(rx_rcv),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .tx_ready(tx_ready),
        .addr(addr),
        .wr_d(wr_d),
        .wr_req(wr_req),
        .rd_req(rd_req),
        .rd_d(rd_d),
        .rd_rdy(rd_rdy),
        .busy(busy),
        .overrun(overrun)
    );

    // uart_tx: capture each started byte, go not-ready for a few cycles
    always @(negedge clk) begin
        if (tx_start) begin
            tx_q.push_back(tx_data);
            tx_ready = 1'b0;
            txr_cnt  = 6;
        end else if (txr_cnt != 0) begin
            txr_cnt = txr_cnt - 1;
            if (txr_cnt == 0) tx_ready = 1'b1;
        end
    end

    // hyper_xface: busy burst after a write, optional delayed rd_rdy after a read
    always @(negedge clk) begin
        if (wr_req) begin
            wr_pulses   = wr_pulses + 1;
            wr_d_seen   = wr_d;
            wr_busy_cnt = 5;
        end else if (wr_busy_cnt != 0) begin
            wr_busy_cnt = wr_busy_cnt - 1;
        end
        rd_rdy = 1'b0;
        if (rd_req) begin
            rd_pulses = rd_pulses + 1;
            if (rd_respond) rd_wait_cnt = 40;
        end else if (rd_wait_cnt != 0) begin
            rd_wait_cnt = rd_wait_cnt - 1;
            if (rd_wait_cnt == 0) begin
                rd_rdy = 1'b1;
                rd_d   = rd_val;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_rcv  = 1'b1;
        @(negedge clk);
        rx_rcv  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [31:0] d);
        send_byte(c);
        send_byte(d[31:24]);
        send_byte(d[23:16]);
        send_byte(d[15:8]);
        send_byte(d[7:0]);
    endtask

    // Wait (bounded) for four reply bytes, allow time for any stray extra byte, then assemble.
    task automatic get_resp(input int limit);
        int n;
        n = 0;
        while ((tx_q.size() < 4) && (n < limit)) begin
            @(negedge clk);
            n = n + 1;
        end
        repeat (20) @(negedge clk);
        resp_n = tx_q.size();
        resp_w = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (i < tx_q.size()) resp_w = {resp_w[23:0], tx_q[i]};
            else                 resp_w = {resp_w[23:0], 8'h00};
        end
        tx_q.delete();
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_data, tx_start, addr, wr_d, wr_req, rd_req, overrun} !== 76'd0) begin
            errors++;
            $display("FAIL reset_outputs: got tx_data=%h tx_start=%b addr=%h wr_d=%h wr_req=%b rd_req=%b overrun=%b, want all 0",
                     tx_data, tx_start, addr, wr_d, wr_req, rd_req, overrun);
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_addr;
        send_frame(8'h01, 32'h0000_0100);
        get_resp(200);
        checks++;
        if (addr !== 32'h0000_0100) begin
            errors++; $display("FAIL addr_reg: got %h want 00000100", addr);
        end
        checks++;
        if (resp_n !== 4) begin
            errors++; $display("FAIL addr_nbytes: got %0d want 4", resp_n);
        end
        checks++;
        if (resp_w !== 32'h0000_0100) begin
            errors++; $display("FAIL addr_resp: got %h want 00000100", resp_w);
        end
    endtask

    task automatic test_write;
        send_frame(8'h02, 32'hDEAD_BEEF);
        get_resp(200);
        checks++;
        if (resp_w !== 32'hDEAD_BEEF || resp_n !== 4) begin
            errors++; $display("FAIL load_resp: got %h (%0d bytes) want deadbeef (4)", resp_w, resp_n);
        end
        checks++;
        if (wr_d !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL load_wr_d: got %h want deadbeef", wr_d);
        end
        busy_force = 1'b1;
        send_frame(8'h03, 32'h0000_0000);
        repeat (10) @(negedge clk);
        checks++;
        if (wr_pulses !== 0) begin
            errors++; $display("FAIL write_held_by_busy: got %0d wr_req cycles want 0", wr_pulses);
        end
        busy_force = 1'b0;
        get_resp(300);
        checks++;
        if (wr_pulses !== 1) begin
            errors++; $display("FAIL write_pulse: got %0d wr_req cycles want 1", wr_pulses);
        end
        checks++;
        if (wr_d_seen !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL write_data: got %h want deadbeef", wr_d_seen);
        end
        checks++;
        if (resp_w !== 32'h0000_0003 || resp_n !== 4) begin
            errors++; $display("FAIL write_resp: got %h (%0d bytes) want 00000003 (4)", resp_w, resp_n);
        end
    endtask

    task automatic test_read;
        rd_respond = 1'b1;
        rd_val     = 32'h1234_5678;
        send_frame(8'h05, 32'hA5A5_A5A5);
        get_resp(400);
        checks++;
        if (rd_pulses !== 1) begin
            errors++; $display("FAIL read_pulse: got %0d rd_req cycles want 1", rd_pulses);
        end
        checks++;
        if (resp_w !== 32'h1234_5678 || resp_n !== 4) begin
            errors++; $display("FAIL readreq_resp: got %h (%0d bytes) want 12345678 (4)", resp_w, resp_n);
        end
        rd_respond = 1'b0;
        send_frame(8'h04, 32'h0000_0000);
        get_resp(200);
        checks++;
        if (resp_w !== 32'h1234_5678 || resp_n !== 4) begin
            errors++; $display("FAIL read_latch: got %h (%0d bytes) want 12345678 (4)", resp_w, resp_n);
        end
    endtask

    task automatic test_rd_timeout;
        rd_respond = 1'b0;
        rd_val     = 32'hCAFE_F00D;
        send_frame(8'h05, 32'h0000_0000);
        get_resp(3000);
        checks++;
        if (resp_w !== 32'hDEAD_BEEF || resp_n !== 4) begin
            errors++; $display("FAIL rd_timeout_resp: got %h (%0d bytes) want deadbeef (4)", resp_w, resp_n);
        end
        send_frame(8'h06, 32'h0000_0000);
        get_resp(200);
        checks++;
        if (resp_w !== 32'h0000_0000 || resp_n !== 4) begin
            errors++; $display("FAIL count_first: got %h (%0d bytes) want 00000000 (4)", resp_w, resp_n);
        end
        send_frame(8'h06, 32'hFFFF_FFFF);
        get_resp(200);
        checks++;
        if (resp_w !== 32'h0000_0001 || resp_n !== 4) begin
            errors++; $display("FAIL count_second: got %h (%0d bytes) want 00000001 (4)", resp_w, resp_n);
        end
        send_frame(8'h04, 32'h0000_0000);
        get_resp(200);
        checks++;
        if (resp_w !== 32'h1234_5678) begin
            errors++; $display("FAIL latch_after_timeout: got %h want 12345678", resp_w);
        end
    endtask

    task automatic test_frame_timeout;
        // Partial COUNT frame; if it were kept, the next bytes would complete it as COUNT.
        send_byte(8'h06);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (150) @(negedge clk);
        checks++;
        if (tx_q.size() !== 0) begin
            errors++; $display("FAIL partial_no_resp: got %0d bytes want 0", tx_q.size());
        end
        send_frame(8'h07, 32'h0000_0000);
        get_resp(200);
        checks++;
        if (resp_w !== 32'h0000_0103 || resp_n !== 4) begin
            errors++; $display("FAIL const_after_discard: got %h (%0d bytes) want 00000103 (4)", resp_w, resp_n);
        end
        send_frame(8'h42, 32'h1111_1111);
        get_resp(200);
        checks++;
        if (resp_w !== 32'hFFFF_FFFF || resp_n !== 4) begin
            errors++; $display("FAIL unknown_cmd: got %h (%0d bytes) want ffffffff (4)", resp_w, resp_n);
        end
    endtask

    task automatic test_overrun;
        int n;
        checks++;
        if (overrun !== 1'b0) begin
            errors++; $display("FAIL overrun_idle: got %b want 0", overrun);
        end
        send_frame(8'h07, 32'h0000_0000);
        n = 0;
        while ((tx_q.size() < 1) && (n < 100)) begin
            @(negedge clk);
            n = n + 1;
        end
        send_byte(8'h55);
        get_resp(200);
        checks++;
        if (overrun !== 1'b1) begin
            errors++; $display("FAIL overrun_set: got %b want 1", overrun);
        end
        checks++;
        if (resp_w !== 32'h0000_0103 || resp_n !== 4) begin
            errors++; $display("FAIL resp_during_overrun: got %h (%0d bytes) want 00000103 (4)", resp_w, resp_n);
        end
        send_frame(8'h07, 32'h0000_0000);
        get_resp(200);
        checks++;
        if (resp_w !== 32'h0000_0103 || overrun !== 1'b1) begin
            errors++; $display("FAIL overrun_sticky: got resp %h overrun %b want 00000103 1", resp_w, overrun);
        end
    endtask

    task automatic test_reset_mid;
        rd_respond = 1'b0;
        send_frame(8'h05, 32'h0000_0000);
        repeat (20) @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++;
        if ({tx_data, tx_start, addr, wr_d, wr_req, rd_req, overrun} !== 76'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got tx_data=%h tx_start=%b addr=%h wr_d=%h wr_req=%b rd_req=%b overrun=%b, want all 0",
                     tx_data, tx_start, addr, wr_d, wr_req, rd_req, overrun);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        tx_q.delete();
        send_frame(8'h06, 32'h0000_0000);
        get_resp(200);
        checks++;
        if (resp_w !== 32'h0000_0000 || resp_n !== 4) begin
            errors++; $display("FAIL count_after_reset: got %h (%0d bytes) want 00000000 (4)", resp_w, resp_n);
        end
        send_frame(8'h07, 32'h0000_0000);
        get_resp(200);
        checks++;
        if (resp_w !== 32'h0000_0103 || overrun !== 1'b0) begin
            errors++; $display("FAIL rx_after_reset: got resp %h overrun %b want 00000103 0", resp_w, overrun);
        end
    endtask

    initial begin
        test_reset;
        test_addr;
        test_write;
        test_read;
        test_rd_timeout;
        test_frame_timeout;
        test_overrun;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/serial_hram_bridge.md
Name: serial_hram_bridge

Overview:
Serial command engine between uart_rx/uart_tx and hyper_xface. It assembles 5-byte command frames from the receiver and drives hyper_xface requests with a proper busy/rd_rdy handshake. It then streams a 4-byte big-endian response to the transmitter. It replaces the ad-hoc inline frame logic at top level and fixes the extra-byte response.

Parameters:
FRAME_TIMEOUT, 24000000, idle cycles after a partial frame before it is discarded (1 s at 24 MHz)
RD_TIMEOUT, 1024, max cycles waiting for rd_rdy (READ_REQ) or busy low (WRITE) before an error response
CONST_VAL, 32'd259, response word for CONST command

Ports:
clk  in  1  system clock (hram_clk domain)
rstn  in  1  asynchronous active-low reset
rx_data  in  8  received byte from uart_rx
rx_rcv  in  1  one-cycle strobe: rx_data valid
tx_data  out  8  byte to uart_tx
tx_start  out  1  one-cycle start strobe to uart_tx
tx_ready  in  1  uart_tx idle; drops within 2 cycles of tx_start
addr  out  32  hyper_xface address
wr_d  out  32  hyper_xface write data
wr_req  out  1  one-cycle write request
rd_req  out  1  one-cycle read request
rd_d  in  32  hyper_xface read data
rd_rdy  in  1  read data valid strobe
busy  in  1  hyper_xface busy
overrun  out  1  sticky: byte arrived while not in RX state; cleared only by reset

Behaviour:
- Reset (async, rstn=0): all outputs 0, state RX, byte count 0, count register 0, read latch 0.
- Frame: byte0 = cmd, bytes1..4 = data[31:24]..data[7:0]. Byte count 0..4; frame is complete on the 5th rx_rcv, then go to EXEC.
- Partial frame (count 1..4) with no rx_rcv for FRAME_TIMEOUT cycles -> count reset to 0, no response.
- rx_rcv outside RX state: byte dropped, overrun<=1.
- States: RX -> EXEC -> (WAIT_IDLE -> ISSUE -> WAIT_DONE) -> TX_BYTE -> TX_HOLD -> TX_WAIT -> RX.
- EXEC, one cycle, commands:
  - 0x01 ADDR: addr<=data, resp=data
  - 0x02 LOAD: wr_d<=data, resp=data
  - 0x03 WRITE: go to WAIT_IDLE
  - 0x04 READ: resp=read latch
  - 0x05 READ_REQ: go to WAIT_IDLE
  - 0x06 COUNT: resp=count, count<=count+1 (32-bit, wraps FFFFFFFF->0)
  - 0x07 CONST: resp=CONST_VAL
  - any other: resp=32'hFFFFFFFF
- WAIT_IDLE: wait busy=0 (timeout counter armed).
- ISSUE: pulse wr_req or rd_req for exactly 1 cycle.
- WAIT_DONE, write: wait busy seen high and then low; resp=32'h00000003.
- WAIT_DONE, read: wait rd_rdy; latch rd_d into the read latch, resp=rd_d (same cycle as rd_rdy).
- Timeout counter reloads on entering WAIT_IDLE and again on entering WAIT_DONE. On expiry -> resp=32'hDEADBEEF, read latch unchanged.
- TX: 4 bytes, MSB first.
  - TX_BYTE: when tx_ready=1, drive tx_data and pulse tx_start 1 cycle.
  - TX_HOLD: ignore tx_ready for 2 cycles.
  - TX_WAIT: wait tx_ready=1, then next byte or RX after the 4th.
- tx_data holds its value until the next load.
- Latency: EXEC to first tx_start is at least 1 cycle, or exactly 1 cycle when tx_ready=1 (non-memory commands).
- rd_rdy/busy activity outside WAIT states is ignored.

Test Plan:
- Send 01 00 00 01 00 -> addr=0x00000100; tx bytes 00 00 01 00; exactly 4 tx_start pulses.
- LOAD 02 DE AD BE EF, then WRITE 03 00 00 00 00 with busy already high for 10 cycles -> wr_req single pulse after busy falls; wr_d=DEADBEEF; response 00 00 00 03.
- READ_REQ 05 xx xx xx xx, model returns rd_rdy with rd_d=0x12345678 after 40 cycles -> response 12 34 56 78; subsequent READ 04 -> same 4 bytes.
- READ_REQ with rd_rdy never asserted -> after RD_TIMEOUT, response DE AD BE EF; next COUNT still works (returns 0, then 1).
- Send 3 bytes, idle FRAME_TIMEOUT (bench override to 100) -> discarded; next full 07 frame -> 00 00 01 03. Unknown cmd 0x42 -> FF FF FF FF.
- Byte injected during TX -> overrun=1 and stays 1; rstn pulse mid-WAIT_DONE -> all outputs 0 immediately, state RX.
